core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the IFU and LSU valid/ready handshakes. It samples the instruction decoder's control outputs (register write, memory enable, memory write, ebreak) and generates one-cycle enables for the IR, register file and PC. It also provides timeout/error detection, halt on ebreak, and a retired-instruction counter.

Parameters:
TIMEOUT, 255, maximum cycles spent in any request/wait state before the error trap fires
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  IFU accepts fetch request
ifu_resp_valid  in  1  fetched instruction valid
ifu_resp_err  in  1  fetch bus error, qualified by ifu_resp_valid
ir_we  out  1  load instruction register, one-cycle pulse
dec_regwr  in  1  decoder Regwr
dec_mem_en  in  1  decoder Mem_wen: instruction accesses memory
dec_memwr  in  1  decoder MemWr: store
dec_ebreak  in  1  instruction is ebreak
lsu_req_valid  out  1  load/store request valid
lsu_req_wr  out  1  1 = store, 0 = load; valid while lsu_req_valid
lsu_req_ready  in  1  LSU accepts request
lsu_resp_valid  in  1  LSU response valid (load data or store ack)
lsu_resp_err  in  1  LSU bus error, qualified by lsu_resp_valid
rf_we  out  1  register-file write enable, one-cycle pulse
pc_we  out  1  PC update, one-cycle pulse
halt  out  1  core halted by ebreak (sticky)
err  out  1  error trap (sticky)
err_code  out  2  01 fetch timeout, 10 LSU timeout, 11 bus error, 00 none
retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- States: IDLE, F_REQ, F_WAIT, DEC, EXE, M_REQ, M_WAIT, WB, HALT, ERR. State and counters are registered. Outputs are Moore-decoded from state, except the latched fields noted below.
- Reset (async, any time, including mid-handshake): state=IDLE, all outputs 0, retire_cnt=0, timeout counter=0, latched decode bits=0.
- IDLE -> F_REQ unconditionally on the first edge after reset releases.
- F_REQ: ifu_req_valid=1. Advance to F_WAIT on ifu_req_valid & ifu_req_ready. ifu_resp_valid is ignored in this state.
- F_WAIT: on ifu_resp_valid:
  - if ifu_resp_err=1: go to ERR, code 11
  - otherwise: ir_we=1 for that same cycle, then go to DEC
- DEC: latch dec_regwr, dec_mem_en, dec_memwr into internal registers.
  - dec_ebreak=1 -> HALT
  - otherwise -> EXE
- EXE: one cycle for ALU settling.
  - latched mem_en=1 -> M_REQ
  - otherwise -> WB
- M_REQ: lsu_req_valid=1, lsu_req_wr = latched memwr. Advance to M_WAIT on handshake.
- M_WAIT: on lsu_resp_valid:
  - if lsu_resp_err=1: go to ERR, code 11
  - otherwise: go to WB
- WB: rf_we = latched regwr (so stores give 0), pc_we=1, retire_cnt += 1 (wraps modulo 2^CNT_W), then go to F_REQ.
- Minimum latency with zero-wait peripherals:
  - ALU/branch/jump instruction: 5 cycles (F_REQ, F_WAIT, DEC, EXE, WB)
  - load/store: 7 cycles
- Timeout:
  - The counter clears on every state change and increments each cycle spent in F_REQ, F_WAIT, M_REQ or M_WAIT.
  - When the counter equals TIMEOUT with no completing event in that cycle, go to ERR with code 01 (fetch states) or 10 (LSU states).
  - If a completing event coincides with the timeout, the event wins and no error is raised.
- HALT: halt=1. No requests or enables are driven. Only reset exits.
- ERR: err=1, err_code held. No requests or enables are driven. Only reset exits.
- ir_we, rf_we and pc_we are never asserted in the same cycle as one another.
- A valid signal, once raised, is held with its payload (lsu_req_wr) stable until ready.

Test Plan:
- Zero-wait ALU instruction (ready=1, resp_valid=1 the cycle after request, dec_regwr=1, dec_mem_en=0) -> ir_we pulses in cycle 2, rf_we and pc_we pulse in cycle 5, retire_cnt=1. Back-to-back, 4 instructions -> retire_cnt=4 after 20 cycles.
- Load (dec_mem_en=1, dec_memwr=0, dec_regwr=1) with lsu_req_ready low for 3 cycles -> lsu_req_valid and lsu_req_wr=0 held stable for 4 cycles, rf_we asserted after the response. Store (memwr=1, regwr=0) -> lsu_req_wr=1, rf_we=0, pc_we=1.
- TIMEOUT=255 with ifu_resp_valid never asserted -> err=1, err_code=01 after exactly 255 F_WAIT cycles. Repeat with resp_valid arriving on cycle 255 -> no error, ir_we=1.
- lsu_resp_valid=1 with lsu_resp_err=1 -> ERR, err_code=11, rf_we and pc_we never pulse, outputs frozen until reset.
- dec_ebreak=1 in DEC -> halt=1 from the next cycle, ifu_req_valid stays 0, retire_cnt unchanged.
- rst asserted mid-M_WAIT, asynchronously between edges -> all outputs 0 immediately, retire_cnt=0. After release: one IDLE cycle, then ifu_req_valid=1.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32I core.
// Drives IFU/LSU handshakes, IR/RF/PC enables, timeout trap, halt and retire count.
module core_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  input  logic             ifu_resp_err,
  output logic             ir_we,
  input  logic             dec_regwr,
  input  logic             dec_mem_en,
  input  logic             dec_memwr,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  output logic             lsu_req_wr,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  input  logic             lsu_resp_err,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FREQ, S_FWAIT, S_DEC, S_EXE,
    S_MREQ, S_MWAIT, S_WB, S_HALT, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_tmo;
  logic             r_regwr;
  logic             r_mem_en;
  logic             r_memwr;
  logic [1:0]       r_code;
  logic [1:0]       w_code;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_waitst;

  // Fires during the TIMEOUT-th consecutive cycle spent in a wait state.
  assign w_hit    = (r_tmo == TW'(TIMEOUT - 1));
  assign w_waitst = (r_state == S_FREQ) || (r_state == S_FWAIT) ||
                    (r_state == S_MREQ) || (r_state == S_MWAIT);

  assign err_code   = r_code;
  assign retire_cnt = r_cnt;

  always_comb begin
    w_next        = r_state;
    w_code        = r_code;
    ifu_req_valid = 1'b0;
    ir_we         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wr    = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    halt          = 1'b0;
    err           = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FREQ;
      S_FREQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          w_next = S_FWAIT;
        end else if (w_hit) begin
          w_next = S_ERR;
          w_code = 2'b01;
        end
      end
      S_FWAIT: begin
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            w_next = S_ERR;
            w_code = 2'b11;
          end else begin
            ir_we  = 1'b1;
            w_next = S_DEC;
          end
        end else if (w_hit) begin
          w_next = S_ERR;
          w_code = 2'b01;
        end
      end
      S_DEC: w_next = dec_ebreak ? S_HALT : S_EXE;
      S_EXE: w_next = r_mem_en ? S_MREQ : S_WB;
      S_MREQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wr    = r_memwr;
        if (lsu_req_ready) begin
          w_next = S_MWAIT;
        end else if (w_hit) begin
          w_next = S_ERR;
          w_code = 2'b10;
        end
      end
      S_MWAIT: begin
        if (lsu_resp_valid) begin
          if (lsu_resp_err) begin
            w_next = S_ERR;
            w_code = 2'b11;
          end else begin
            w_next = S_WB;
          end
        end else if (w_hit) begin
          w_next = S_ERR;
          w_code = 2'b10;
        end
      end
      S_WB: begin
        rf_we  = r_regwr;
        pc_we  = 1'b1;
        w_next = S_FREQ;
      end
      S_HALT: halt = 1'b1;
      S_ERR:  err  = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmo    <= '0;
      r_regwr  <= 1'b0;
      r_mem_en <= 1'b0;
      r_memwr  <= 1'b0;
      r_code   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (w_waitst) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (r_state == S_DEC) begin
        r_regwr  <= dec_regwr;
        r_mem_en <= dec_mem_en;
        r_memwr  <= dec_memwr;
      end
      if (r_state == S_WB) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed table-driven bench for core_seq_ctrl: instruction flows,
// stalls, timeouts, bus error, halt and asynchronous reset.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic        ir_we;
  logic        dec_regwr, dec_mem_en, dec_memwr, dec_ebreak;
  logic        lsu_req_valid, lsu_req_wr, lsu_req_ready;
  logic        lsu_resp_valid, lsu_resp_err;
  logic        rf_we, pc_we, halt, err;
  logic [1:0]  err_code;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  core_seq_ctrl #(.TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err),
    .ir_we(ir_we),
    .dec_regwr(dec_regwr), .dec_mem_en(dec_mem_en),
    .dec_memwr(dec_memwr), .dec_ebreak(dec_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wr(lsu_req_wr),
    .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_err(lsu_resp_err),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .err(err),
    .err_code(err_code), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // in : {ifu_rdy, ifu_rv, ifu_re, regwr, mem_en, memwr, ebreak,
  //       lsu_rdy, lsu_rv, lsu_re}
  // exp: {ifu_req_valid, ir_we, lsu_req_valid, lsu_req_wr,
  //       rf_we, pc_we, halt, err, err_code[1:0]}
  typedef struct {
    logic [9:0]  in;
    logic [9:0]  exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  localparam logic [9:0] I_ALU = 10'b1101000000;
  localparam logic [9:0] I_LDS = 10'b1101100000;
  localparam logic [9:0] I_LDG = 10'b1101100100;
  localparam logic [9:0] I_LDR = 10'b1101100110;
  localparam logic [9:0] I_ST  = 10'b1100110110;
  localparam logic [9:0] I_BRK = 10'b1100001000;
  localparam logic [9:0] I_LDE = 10'b1101100111;

  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_FREQ = 10'b1000000000;
  localparam logic [9:0] O_IR   = 10'b0100000000;
  localparam logic [9:0] O_LDQ  = 10'b0010000000;
  localparam logic [9:0] O_STQ  = 10'b0011000000;
  localparam logic [9:0] O_WBR  = 10'b0000110000;
  localparam logic [9:0] O_WBP  = 10'b0000010000;
  localparam logic [9:0] O_HALT = 10'b0000001000;
  localparam logic [9:0] O_EBUS = 10'b0000000111;
  localparam logic [9:0] O_ETF  = 10'b0000000101;
  localparam logic [9:0] O_ETL  = 10'b0000000110;

  task automatic add(input logic [9:0] i, input logic [9:0] e,
                     input logic [31:0] c);
    vec_t v;
    v.in  = i;
    v.exp = e;
    v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [9:0] v);
    {ifu_req_ready, ifu_resp_valid, ifu_resp_err, dec_regwr, dec_mem_en,
     dec_memwr, dec_ebreak, lsu_req_ready, lsu_resp_valid, lsu_resp_err} = v;
  endtask

  function automatic logic [9:0] outs();
    return {ifu_req_valid, ir_we, lsu_req_valid, lsu_req_wr,
            rf_we, pc_we, halt, err, err_code};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(10'b0);
    @(negedge clk);
    #1;
    chk("reset_outs", {22'b0, outs()}, 32'h0);
    chk("reset_cnt", retire_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic steps(input logic [9:0] v, input int n);
    drive(v);
    repeat (n) @(negedge clk);
  endtask

  int bad;

  initial begin
    ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_err = 0;
    dec_regwr = 0; dec_mem_en = 0; dec_memwr = 0; dec_ebreak = 0;
    lsu_req_ready = 0; lsu_resp_valid = 0; lsu_resp_err = 0;

    add(10'b0, O_NONE, 0);
    for (int k = 0; k < 4; k++) begin
      add(I_ALU, O_FREQ, k);
      add(I_ALU, O_IR,   k);
      add(I_ALU, O_NONE, k);
      add(I_ALU, O_NONE, k);
      add(I_ALU, O_WBR,  k);
    end
    add(I_LDS, O_FREQ, 4);
    add(I_LDS, O_IR,   4);
    add(I_LDS, O_NONE, 4);
    add(I_LDS, O_NONE, 4);
    add(I_LDS, O_LDQ,  4);
    add(I_LDS, O_LDQ,  4);
    add(I_LDS, O_LDQ,  4);
    add(I_LDG, O_LDQ,  4);
    add(I_LDR, O_NONE, 4);
    add(I_LDR, O_WBR,  4);
    add(I_ST,  O_FREQ, 5);
    add(I_ST,  O_IR,   5);
    add(I_ST,  O_NONE, 5);
    add(I_ST,  O_NONE, 5);
    add(I_ST,  O_STQ,  5);
    add(I_ST,  O_NONE, 5);
    add(I_ST,  O_WBP,  5);
    add(I_BRK, O_FREQ, 6);
    add(I_BRK, O_IR,   6);
    add(I_BRK, O_NONE, 6);
    add(I_BRK, O_HALT, 6);
    add(I_BRK, O_HALT, 6);
    add(I_BRK, O_HALT, 6);

    do_reset();
    foreach (tbl[n]) begin
      drive(tbl[n].in);
      #1;
      chk($sformatf("vec%0d_outs", n), {22'b0, outs()}, {22'b0, tbl[n].exp});
      chk($sformatf("vec%0d_cnt", n), retire_cnt, tbl[n].cnt);
      @(negedge clk);
    end

    // Fetch response never arrives: trap after 255 F_WAIT cycles.
    do_reset();
    @(negedge clk);
    drive(10'b1000000000);
    #1;
    chk("tmo_freq", {31'b0, ifu_req_valid}, 32'h1);
    @(negedge clk);
    drive(10'b0);
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      #1;
      if (err || ifu_req_valid || ir_we) bad++;
      @(negedge clk);
    end
    chk("tmo_quiet", bad, 0);
    #1;
    chk("tmo_fetch_err", {22'b0, outs()}, {22'b0, O_ETF});

    // Response on the 255th cycle wins over the timeout.
    do_reset();
    @(negedge clk);
    drive(10'b1000000000);
    @(negedge clk);
    drive(10'b0);
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      if (i == 255) ifu_resp_valid = 1'b1;
      #1;
      if (i < 255 && (err || ir_we)) bad++;
      if (i == 255) chk("tmo_edge_irwe", {31'b0, ir_we}, 32'h1);
      @(negedge clk);
    end
    chk("tmo_edge_quiet", bad, 0);
    drive(10'b0);
    #1;
    chk("tmo_edge_noerr", {22'b0, outs()}, {22'b0, O_NONE});

    // LSU request never accepted: trap with code 10.
    do_reset();
    steps(I_LDS, 5);
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      #1;
      if (!lsu_req_valid || lsu_req_wr || err) bad++;
      @(negedge clk);
    end
    chk("tmo_lsu_hold", bad, 0);
    #1;
    chk("tmo_lsu_err", {22'b0, outs()}, {22'b0, O_ETL});

    // LSU bus error: trap code 11, frozen, no writeback.
    do_reset();
    steps(I_LDE, 7);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (outs() !== O_EBUS) bad++;
      @(negedge clk);
    end
    chk("buserr_frozen", bad, 0);
    chk("buserr_cnt", retire_cnt, 32'h0);
    chk("buserr_code", {30'b0, err_code}, 32'h3);

    // Asynchronous reset while waiting on the LSU response.
    do_reset();
    steps(I_ALU, 6);
    steps(I_LDG, 5);
    #1;
    chk("arst_pre_cnt", retire_cnt, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outs", {22'b0, outs()}, 32'h0);
    chk("arst_cnt", retire_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(I_ALU);
    #1;
    chk("arst_idle", {31'b0, ifu_req_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("arst_freq", {31'b0, ifu_req_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
